// File: rtl/seq_divider_8bit.sv
// Sequential unsigned restoring divider: one trial subtraction (A + ~B + 1) per clock.
// A division takes 9 clocks from an accepted start to the single-cycle done pulse.
module seq_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] den_q;
    logic [CntW-1:0]  cnt_q;
    logic             dz_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;

    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} + {2'b01, ~den_q} + {{(WIDTH + 1){1'b0}}, 1'b1};
        no_borrow = trial[WIDTH+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is not accepted.
                    if (start && !done) begin
                        quo_q   <= dividend;
                        rem_q   <= '0;
                        den_q   <= divisor;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        dz_q    <= (divisor == '0);
                        state_q <= (divisor == '0) ? StFinish : StRun;
                    end
                end
                StRun: begin
                    rem_q <= no_borrow ? trial[WIDTH:0] : rem_shift;
                    quo_q <= {quo_q[WIDTH-2:0], no_borrow};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) state_q <= StFinish;
                end
                StFinish: begin
                    // Divide-by-zero waits one extra cycle here so done lands two clocks after start.
                    if (dz_q && cnt_q == '0) begin
                        cnt_q <= CntW'(1);
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (dz_q) begin
                            quotient    <= '1;
                            remainder   <= quo_q;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= quo_q;
                            remainder   <= rem_q[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed and random checks for seq_divider_8bit: latency, busy width, results,
// divide-by-zero, reset abort and start abuse.
module tb_seq_divider_8bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // abuse: re-pulse start with junk operands mid-run, in FINISH and on the done cycle,
    // and scramble the operand inputs right after acceptance.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input bit abuse, input bit check_timing);
        logic [7:0] eq, er;
        logic       edz;
        int         n, bcnt, extra;
        if (b == 8'h00) begin
            eq = 8'hFF; er = a; edz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bcnt = 0;
        if (abuse) begin
            dividend = ~a; divisor = b ^ 8'h5A;
        end
        while (done !== 1'b1 && n < 30) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
            start = 1'b0;
            if (abuse && (n == 3 || n == 9)) begin
                start = 1'b1; dividend = 8'hC3; divisor = 8'h05;
            end
        end
        if (check_timing) begin
            check({tag, " latency"}, n - 1, (b == 8'h00) ? 2 : 9);
            check({tag, " busy cycles"}, bcnt, (b == 8'h00) ? 2 : 9);
            check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        end
        check({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
        check({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        if (abuse) begin
            start = 1'b1; dividend = 8'h11; divisor = 8'h03;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done width"}, {31'd0, done}, 32'd0);
        if (abuse) begin
            extra = 0;
            repeat (14) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            check({tag, " no second op"}, extra, 0);
            check({tag, " quotient held"}, {24'd0, quotient}, {24'd0, eq});
        end
    endtask

    initial begin
        int ghost;
        logic [7:0] ra, rb;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", {24'd0, quotient}, 32'd0);
        check("reset remainder", {24'd0, remainder}, 32'd0);
        check("reset dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("basic AA/43", 8'hAA, 8'h43, 1'b0, 1'b1);
        run_div("FF/01", 8'hFF, 8'h01, 1'b0, 1'b1);
        run_div("FF/FF", 8'hFF, 8'hFF, 1'b0, 1'b1);
        run_div("01/02", 8'h01, 8'h02, 1'b0, 1'b1);
        run_div("00/05", 8'h00, 8'h05, 1'b0, 1'b1);
        run_div("dz 07/00", 8'h07, 8'h00, 1'b0, 1'b1);
        run_div("after dz 64/07", 8'h64, 8'h07, 1'b0, 1'b1);

        // Reset in the middle of a run.
        run_div("pre-reset 93/0B", 8'h93, 8'h0B, 1'b0, 1'b0);
        @(negedge clk);
        dividend = 8'hC8; divisor = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", {24'd0, quotient}, 32'd0);
        check("abort remainder", {24'd0, remainder}, 32'd0);
        check("abort dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ghost = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) ghost++;
        end
        check("no done after abort", ghost, 0);
        run_div("post-reset 64/07", 8'h64, 8'h07, 1'b0, 1'b1);

        run_div("abuse 64/07", 8'h64, 8'h07, 1'b1, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            run_div("random", ra, rb, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
